vj_det_grouper: RTL and testbench
=================================

# vj_det_grouper

Groups raw 19x19 window hits from the Viola-Jones detector into merged face boxes, one pass per frame. It sits directly downstream of the detector top. It consumes `det_valid/det_x/det_y/det_w/det_h` plus the detector `busy` line. When the detector's busy line falls, the block emits one union bounding box per sufficiently supported group over a valid/ready stream.

## Interface
Parameters:
- `MAX_GROUPS`, 16: group table entries (power of two, ≤ 64).
- `FIFO_DEPTH`, 4: input detection FIFO depth (power of two).
- `TOL`, 4: max |dx| and |dy| in pixels from a group anchor for membership.
- `MIN_HITS`, 2: minimum member count for a group to be emitted.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high; clears all state.
- `det_valid`  in  1  one-cycle detection strobe from the detector.
- `det_x`  in  10  window left.
- `det_y`  in  9  window top.
- `det_w`  in  10  window width.
- `det_h`  in  9  window height.
- `scan_busy`  in  1  detector `busy`; a 1→0 transition marks end of frame.
- `out_valid`  out  1  merged box available.
- `out_ready`  in  1  consumer accepts when `out_valid && out_ready`.
- `out_x`, `out_y`  out  10/9  union box top-left.
- `out_w`, `out_h`  out  10/9  union box size.
- `out_hits`  out  8  member count, saturating at 255.
- `frame_done`  out  1  one-cycle pulse after the last box of a frame.
- `frame_groups`  out  7  groups emitted this frame; valid with `frame_done`.
- `frame_drops`  out  8  detections dropped this frame (FIFO full or table full), saturating; valid with `frame_done`.
- `busy`  out  1  high whenever state ≠ IDLE, the FIFO is non-empty, or EOF is pending.

## Operation
- **Input FIFO**
  - A `det_valid` cycle writes {x,y,w,h} at that edge if the FIFO is not full.
  - If the FIFO is full, the detection is discarded and the drop counter increments.
  - Push and pop in the same cycle are legal; occupancy is unchanged.
- **EOF detect**
  - A registered `scan_busy` falling edge sets `eof_pend`.
  - A further falling edge while `eof_pend` is already set is ignored.
- **Group entry contents:** `used`, anchor (ax, ay), w, h, min_x, min_y, max_x2 (= max x+w), max_y2 (= max y+h), hits.
- **Allocation:** entries are allocated in index order; `n_used` counts them.
- **FSM states:** IDLE, SEARCH, UPDATE, ALLOC, EMIT, DONE.
- **IDLE**
  - If the FIFO is non-empty: pop the head into a holding register, set idx=0, go to SEARCH, or go to ALLOC when `n_used`=0.
  - Else if `eof_pend`: set idx=0, go to EMIT.
- **SEARCH:** compare entry idx against the held detection, one entry per cycle.
  - Match condition: w==det_w, h==det_h, |det_x−ax|≤TOL and |det_y−ay|≤TOL.
  - The match compare uses the anchor only, not the union box, so groups cannot drift.
  - On the first match, go to UPDATE.
  - Else if idx==n_used−1, go to ALLOC.
  - Else idx++.
- **UPDATE:** widen min/max with the detection, hits += 1 (saturating), then go to IDLE.
- **ALLOC**
  - If n_used<MAX_GROUPS: the new entry gets anchor=min=(det_x,det_y), max2=(det_x+det_w, det_y+det_h), hits=1; n_used++.
  - Else: drop the detection and increment the drop counter.
  - Then go to IDLE.
- **EMIT**
  - For idx < n_used: if hits ≥ MIN_HITS, present `out_valid` and hold all out_* stable until accepted, then idx++.
  - Entries with hits < MIN_HITS are skipped in 1 cycle.
  - When idx reaches n_used, go to DONE.
  - Outputs: out_x=min_x, out_y=min_y, out_w=max_x2−min_x, out_h=max_y2−min_y.
  - Compute max_x2/max_y2 at 11/10 bits; results are truncated to port width.
- **DONE**
  - Pulse `frame_done` with the final counts.
  - Clear `eof_pend`, `n_used`, all `used` bits, and the drop and group counters.
  - Go to IDLE.
- **Ordering and EMIT-time inputs**
  - The FIFO is always drained before EMIT, so a detection arriving in the same cycle as the `scan_busy` fall belongs to the current frame.
  - Detections arriving during EMIT/DONE enqueue (or drop if the FIFO is full) and belong to the next frame.

## Timing
- Reset values:
  - out_valid=0, frame_done=0, out_* data=0, frame_groups=0, frame_drops=0, busy=0.
  - FIFO empty, n_used=0, eof_pend=0, state IDLE.
- Reset asserted mid-frame or mid-EMIT: all of the above hold on the next edge; the pending box is lost and no `frame_done` is produced.
- Latency per detection from FIFO head:
  - Match at index k: 1 (IDLE) + k+1 (SEARCH) + 1 (UPDATE) cycles.
  - No match: 1 + n_used + 1 cycles.
  - Empty table: 2 cycles.
- EOF to first `out_valid`: 2 cycles after `scan_busy` falls with the FIFO empty and idle (1 edge-detect register + IDLE→EMIT).
- `frame_done` fires the cycle after the last acceptance or skip.
- `out_valid` never drops without a handshake.

## Test plan
- **Single cluster:** three detections (100,50),(102,52),(98,49), all 19x19, then scan_busy falls → one box x=98, y=49, w=23, h=22, hits=3; frame_done with groups=1, drops=0.
- **Separation and MIN_HITS:** two hits at (10,10), one at (200,100) → only the (10,10) box (hits=2) is emitted; groups=1.
- **Tolerance boundary:** anchor (50,50), then (54,46) joins; then (55,50) opens a new group (dx=5 > TOL).
- **Overflow:** 17 distinct far-apart detections with slow spacing → 16 groups allocated, frame_drops=1.
- **Burst:** 6 back-to-back `det_valid` cycles while SEARCH is stalled → the FIFO fills, drops=2 counted.
- **Backpressure and reset:** out_ready held low 5 cycles → out_* stable throughout; reset asserted mid-EMIT → out_valid=0 next cycle, no frame_done, busy=0.

Source files
------------

// File: rtl/vj_det_grouper.sv
// vj_det_grouper
// Merges raw Viola-Jones window hits into union bounding boxes. Detections
// are buffered in a small FIFO, matched against a group table by anchor
// position and window size, and when the detector's busy line falls the
// table is walked once to emit every sufficiently supported group.
module vj_det_grouper #(
    parameter int MAX_GROUPS = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int TOL        = 4,
    parameter int MIN_HITS   = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       det_valid,
    input  logic [9:0] det_x,
    input  logic [8:0] det_y,
    input  logic [9:0] det_w,
    input  logic [8:0] det_h,
    input  logic       scan_busy,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [9:0] out_x,
    output logic [8:0] out_y,
    output logic [9:0] out_w,
    output logic [8:0] out_h,
    output logic [7:0] out_hits,
    output logic       frame_done,
    output logic [6:0] frame_groups,
    output logic [7:0] frame_drops,
    output logic       busy
);

    localparam int AW = $clog2(MAX_GROUPS);
    localparam int IW = AW + 1;
    localparam int FW = $clog2(FIFO_DEPTH);

    typedef struct packed {
        logic [9:0] x;
        logic [8:0] y;
        logic [9:0] w;
        logic [8:0] h;
    } det_t;

    typedef struct packed {
        logic        used;
        logic [9:0]  ax;
        logic [8:0]  ay;
        logic [9:0]  w;
        logic [8:0]  h;
        logic [9:0]  min_x;
        logic [8:0]  min_y;
        logic [10:0] max_x2;
        logic [9:0]  max_y2;
        logic [7:0]  hits;
    } entry_t;

    typedef enum logic [2:0] {
        IDLE,
        SEARCH,
        UPDATE,
        ALLOC,
        EMIT,
        DONE
    } state_t;

    state_t        state_q, state_d;
    det_t          fifo_mem_q [FIFO_DEPTH];
    det_t          fifo_mem_d [FIFO_DEPTH];
    logic [FW:0]   wr_ptr_q, wr_ptr_d;
    logic [FW:0]   rd_ptr_q, rd_ptr_d;
    det_t          hold_q, hold_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [IW-1:0] n_used_q, n_used_d;
    entry_t        tbl_q [MAX_GROUPS];
    entry_t        tbl_d [MAX_GROUPS];
    logic          eof_pend_q, eof_pend_d;
    logic          scan_busy_q, scan_busy_d;
    logic [7:0]    drop_cnt_q, drop_cnt_d;
    logic [6:0]    grp_cnt_q, grp_cnt_d;

    logic [FW:0]   fifo_count;
    logic          fifo_empty;
    logic          fifo_full;
    logic          push;
    logic          pop;
    logic          fifo_drop;
    logic          table_drop;
    logic          frame_clear;
    logic          scan_fall;
    det_t          det_in;
    det_t          fifo_head;
    logic [AW-1:0] cur_addr;
    entry_t        cur;
    entry_t        upd_entry;
    entry_t        new_entry;
    logic [10:0]   dx;
    logic [10:0]   adx;
    logic [9:0]    dy;
    logic [9:0]    ady;
    logic [10:0]   hold_x2;
    logic [9:0]    hold_y2;
    logic          match;
    logic          emit_qual;
    logic [1:0]    drop_inc;
    logic [8:0]    drop_sum;

    // FIFO status, write acceptance and end-of-frame edge detection
    always_comb begin
        det_in      = '{x: det_x, y: det_y, w: det_w, h: det_h};
        fifo_count  = wr_ptr_q - rd_ptr_q;
        fifo_empty  = (fifo_count == '0);
        fifo_full   = (fifo_count == (FW + 1)'(FIFO_DEPTH));
        fifo_head   = fifo_mem_q[rd_ptr_q[FW-1:0]];
        push        = det_valid && !fifo_full;
        fifo_drop   = det_valid && fifo_full;
        scan_fall   = scan_busy_q && !scan_busy;
        scan_busy_d = scan_busy;
        cur_addr    = idx_q[AW-1:0];
    end

    // Anchor match against the indexed entry, candidate entry updates and emit data
    always_comb begin
        cur     = tbl_q[cur_addr];
        dx      = {1'b0, hold_q.x} - {1'b0, cur.ax};
        adx     = dx[10] ? (~dx + 11'd1) : dx;
        dy      = {1'b0, hold_q.y} - {1'b0, cur.ay};
        ady     = dy[9] ? (~dy + 10'd1) : dy;
        match   = cur.used && (cur.w == hold_q.w) && (cur.h == hold_q.h) &&
                  (adx <= 11'(TOL)) && (ady <= 10'(TOL));
        hold_x2 = {1'b0, hold_q.x} + {1'b0, hold_q.w};
        hold_y2 = {1'b0, hold_q.y} + {1'b0, hold_q.h};

        upd_entry        = cur;
        upd_entry.min_x  = (hold_q.x < cur.min_x) ? hold_q.x : cur.min_x;
        upd_entry.min_y  = (hold_q.y < cur.min_y) ? hold_q.y : cur.min_y;
        upd_entry.max_x2 = (hold_x2 > cur.max_x2) ? hold_x2 : cur.max_x2;
        upd_entry.max_y2 = (hold_y2 > cur.max_y2) ? hold_y2 : cur.max_y2;
        upd_entry.hits   = (cur.hits == 8'hFF) ? cur.hits : cur.hits + 8'd1;

        new_entry = '{used: 1'b1, ax: hold_q.x, ay: hold_q.y, w: hold_q.w, h: hold_q.h,
                      min_x: hold_q.x, min_y: hold_q.y, max_x2: hold_x2,
                      max_y2: hold_y2, hits: 8'd1};

        emit_qual = (state_q == EMIT) && (idx_q < n_used_q) && (cur.hits >= 8'(MIN_HITS));
        out_valid = emit_qual;
        out_x     = emit_qual ? cur.min_x : '0;
        out_y     = emit_qual ? cur.min_y : '0;
        out_w     = emit_qual ? 10'(cur.max_x2 - {1'b0, cur.min_x}) : '0;
        out_h     = emit_qual ? 9'(cur.max_y2 - {1'b0, cur.min_y}) : '0;
        out_hits  = emit_qual ? cur.hits : '0;
    end

    // Grouping FSM: pop, linear search, merge or allocate, then the emit walk
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        n_used_d    = n_used_q;
        hold_d      = hold_q;
        tbl_d       = tbl_q;
        grp_cnt_d   = grp_cnt_q;
        pop         = 1'b0;
        table_drop  = 1'b0;
        frame_clear = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    hold_d  = fifo_head;
                    idx_d   = '0;
                    state_d = (n_used_q == '0) ? ALLOC : SEARCH;
                end else if (eof_pend_q) begin
                    idx_d   = '0;
                    state_d = EMIT;
                end
            end
            SEARCH: begin
                if (match) begin
                    state_d = UPDATE;
                end else if (idx_q == n_used_q - IW'(1)) begin
                    state_d = ALLOC;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            UPDATE: begin
                tbl_d[cur_addr] = upd_entry;
                state_d         = IDLE;
            end
            ALLOC: begin
                if (n_used_q < IW'(MAX_GROUPS)) begin
                    tbl_d[n_used_q[AW-1:0]] = new_entry;
                    n_used_d                = n_used_q + IW'(1);
                end else begin
                    table_drop = 1'b1;
                end
                state_d = IDLE;
            end
            EMIT: begin
                if (idx_q >= n_used_q) begin
                    state_d = DONE;
                end else if (!emit_qual || out_ready) begin
                    if (emit_qual) begin
                        grp_cnt_d = grp_cnt_q + 7'd1;
                    end
                    if (idx_q == n_used_q - IW'(1)) begin
                        state_d = DONE;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
            end
            DONE: begin
                frame_clear = 1'b1;
                n_used_d    = '0;
                idx_d       = '0;
                grp_cnt_d   = '0;
                for (int i = 0; i < MAX_GROUPS; i++) begin
                    tbl_d[i].used = 1'b0;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // FIFO storage and pointer advance; simultaneous push and pop keep occupancy
    always_comb begin
        fifo_mem_d = fifo_mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        if (push) begin
            fifo_mem_d[wr_ptr_q[FW-1:0]] = det_in;
            wr_ptr_d                     = wr_ptr_q + (FW + 1)'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + (FW + 1)'(1);
        end
    end

    // Saturating drop counter and pending-EOF flag; a drop or fall seen in DONE starts the next frame
    always_comb begin
        drop_inc   = {1'b0, fifo_drop} + {1'b0, table_drop};
        drop_sum   = {1'b0, drop_cnt_q} + {7'd0, drop_inc};
        drop_cnt_d = drop_sum[8] ? 8'hFF : drop_sum[7:0];
        eof_pend_d = eof_pend_q | scan_fall;
        if (frame_clear) begin
            drop_cnt_d = {7'd0, fifo_drop};
            eof_pend_d = scan_fall;
        end
    end

    assign frame_done   = (state_q == DONE);
    assign frame_groups = grp_cnt_q;
    assign frame_drops  = drop_cnt_q;
    assign busy         = (state_q != IDLE) || !fifo_empty || eof_pend_q;

    // State registers with synchronous reset clearing everything
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            fifo_mem_q  <= '{default: '0};
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            hold_q      <= '0;
            idx_q       <= '0;
            n_used_q    <= '0;
            tbl_q       <= '{default: '0};
            eof_pend_q  <= 1'b0;
            scan_busy_q <= 1'b0;
            drop_cnt_q  <= '0;
            grp_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            fifo_mem_q  <= fifo_mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            hold_q      <= hold_d;
            idx_q       <= idx_d;
            n_used_q    <= n_used_d;
            tbl_q       <= tbl_d;
            eof_pend_q  <= eof_pend_d;
            scan_busy_q <= scan_busy_d;
            drop_cnt_q  <= drop_cnt_d;
            grp_cnt_q   <= grp_cnt_d;
        end
    end

endmodule

// File: tb/tb_vj_det_grouper.sv
// Testbench for vj_det_grouper: table-driven frames with hand-derived boxes,
// plus hand-written overflow, burst, backpressure and reset sequences.
// Expected boxes go into a queue as each frame is driven and are popped by
// a monitor whenever the DUT completes an output handshake.
module tb_vj_det_grouper;

    logic       clk = 1'b0;
    logic       reset;
    logic       det_valid;
    logic [9:0] det_x;
    logic [8:0] det_y;
    logic [9:0] det_w;
    logic [8:0] det_h;
    logic       scan_busy;
    logic       out_valid;
    logic       out_ready;
    logic [9:0] out_x;
    logic [8:0] out_y;
    logic [9:0] out_w;
    logic [8:0] out_h;
    logic [7:0] out_hits;
    logic       frame_done;
    logic [6:0] frame_groups;
    logic [7:0] frame_drops;
    logic       busy;

    always #5 clk = ~clk;

    vj_det_grouper #(
        .MAX_GROUPS(16),
        .FIFO_DEPTH(4),
        .TOL(4),
        .MIN_HITS(2)
    ) dut (
        .clk(clk),
        .reset(reset),
        .det_valid(det_valid),
        .det_x(det_x),
        .det_y(det_y),
        .det_w(det_w),
        .det_h(det_h),
        .scan_busy(scan_busy),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_x(out_x),
        .out_y(out_y),
        .out_w(out_w),
        .out_h(out_h),
        .out_hits(out_hits),
        .frame_done(frame_done),
        .frame_groups(frame_groups),
        .frame_drops(frame_drops),
        .busy(busy)
    );

    typedef struct {
        int frame;
        int x;
        int y;
        int w;
        int h;
    } det_vec_t;

    typedef struct {
        int frame;
        int x;
        int y;
        int w;
        int h;
        int hits;
    } box_vec_t;

    typedef struct {
        int x;
        int y;
        int w;
        int h;
        int hits;
    } box_t;

    det_vec_t dets[$];
    box_vec_t boxes[$];
    box_t     exp_q[$];
    box_t     mon_exp;
    int       frame_groups_exp[4];
    int       frame_drops_exp[4];

    int cmp_count  = 0;
    int fail_count = 0;
    int done_count = 0;
    int exp_groups = 0;
    int exp_drops  = 0;

    task automatic checkOutput(input string name, input int actual, input int expected);
        cmp_count++;
        if (actual != expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic void addDet(input int f, input int x, input int y, input int w, input int h);
        det_vec_t d;
        d.frame = f; d.x = x; d.y = y; d.w = w; d.h = h;
        dets.push_back(d);
    endfunction

    function automatic void addBox(input int f, input int x, input int y, input int w, input int h,
                                   input int hits);
        box_vec_t b;
        b.frame = f; b.x = x; b.y = y; b.w = w; b.h = h; b.hits = hits;
        boxes.push_back(b);
    endfunction

    function automatic void expectBox(input int x, input int y, input int w, input int h, input int hits);
        box_t b;
        b.x = x; b.y = y; b.w = w; b.h = h; b.hits = hits;
        exp_q.push_back(b);
    endfunction

    task automatic waitIdle();
        int n = 0;
        while (busy && n < 300) begin
            step();
            n++;
        end
        if (busy) checkOutput("idle_timeout", 1, 0);
    endtask

    task automatic applyStimulus(input int x, input int y, input int w, input int h);
        step();
        det_valid = 1'b1;
        det_x     = 10'(x);
        det_y     = 9'(y);
        det_w     = 10'(w);
        det_h     = 9'(h);
        step();
        det_valid = 1'b0;
        waitIdle();
    endtask

    task automatic endFrame(input int groups, input int drops, output int lat);
        int base;
        int n;
        base       = done_count;
        exp_groups = groups;
        exp_drops  = drops;
        step();
        scan_busy = 1'b0;
        lat = 0;
        while (!out_valid && !frame_done && lat < 50) begin
            step();
            lat++;
        end
        n = 0;
        while (done_count == base && n < 2000) begin
            step();
            n++;
        end
        checkOutput("frame_done_seen", done_count - base, 1);
        checkOutput("queue_drained", exp_q.size(), 0);
        scan_busy = 1'b1;
    endtask

    // Scoreboard monitor: sample mid-cycle, pop on handshake, check frame totals
    always @(negedge clk) begin
        if (!reset) begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_box", 1, 0);
                end else begin
                    mon_exp = exp_q.pop_front();
                    checkOutput("box_x", int'(out_x), mon_exp.x);
                    checkOutput("box_y", int'(out_y), mon_exp.y);
                    checkOutput("box_w", int'(out_w), mon_exp.w);
                    checkOutput("box_h", int'(out_h), mon_exp.h);
                    checkOutput("box_hits", int'(out_hits), mon_exp.hits);
                end
            end
            if (frame_done) begin
                done_count++;
                checkOutput("frame_groups", int'(frame_groups), exp_groups);
                checkOutput("frame_drops", int'(frame_drops), exp_drops);
            end
        end
    end

    // Global watchdog so a wedged run still reports and terminates
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int lat;
        int base;
        int n;
        int bx[6];
        int by[6];

        reset     = 1'b1;
        det_valid = 1'b0;
        det_x     = '0;
        det_y     = '0;
        det_w     = '0;
        det_h     = '0;
        scan_busy = 1'b1;
        out_ready = 1'b1;

        // Frame 0: single cluster
        addDet(0, 100, 50, 19, 19);
        addDet(0, 102, 52, 19, 19);
        addDet(0, 98, 49, 19, 19);
        addBox(0, 98, 49, 23, 22, 3);
        frame_groups_exp[0] = 1; frame_drops_exp[0] = 0;
        // Frame 1: separation and MIN_HITS filtering
        addDet(1, 10, 10, 19, 19);
        addDet(1, 10, 10, 19, 19);
        addDet(1, 200, 100, 19, 19);
        addBox(1, 10, 10, 19, 19, 2);
        frame_groups_exp[1] = 1; frame_drops_exp[1] = 0;
        // Frame 2: tolerance edge, new anchor at dx=5, size mismatch
        addDet(2, 50, 50, 19, 19);
        addDet(2, 54, 46, 19, 19);
        addDet(2, 55, 50, 19, 19);
        addDet(2, 58, 54, 19, 19);
        addDet(2, 50, 50, 24, 24);
        addBox(2, 50, 46, 23, 23, 2);
        addBox(2, 55, 50, 22, 23, 2);
        frame_groups_exp[2] = 2; frame_drops_exp[2] = 0;
        // Frame 3: right/bottom edge where x+w and y+h exceed the port width
        addDet(3, 1003, 490, 19, 19);
        addDet(3, 1006, 493, 19, 19);
        addBox(3, 1003, 490, 22, 22, 2);
        frame_groups_exp[3] = 1; frame_drops_exp[3] = 0;

        repeat (3) step();
        checkOutput("reset_out_valid", int'(out_valid), 0);
        checkOutput("reset_frame_done", int'(frame_done), 0);
        checkOutput("reset_busy", int'(busy), 0);
        checkOutput("reset_out_x", int'(out_x), 0);
        checkOutput("reset_frame_groups", int'(frame_groups), 0);
        checkOutput("reset_frame_drops", int'(frame_drops), 0);
        reset = 1'b0;
        step();

        for (int f = 0; f < 4; f++) begin
            foreach (dets[i]) begin
                if (dets[i].frame == f) applyStimulus(dets[i].x, dets[i].y, dets[i].w, dets[i].h);
            end
            foreach (boxes[i]) begin
                if (boxes[i].frame == f)
                    expectBox(boxes[i].x, boxes[i].y, boxes[i].w, boxes[i].h, boxes[i].hits);
            end
            endFrame(frame_groups_exp[f], frame_drops_exp[f], lat);
            if (f == 0) checkOutput("eof_latency", lat, 2);
        end

        // Overflow: 17 distinct groups, the last one has nowhere to go
        for (int i = 0; i < 17; i++) applyStimulus(i * 50, 20, 19, 19);
        for (int i = 0; i < 16; i++) begin
            applyStimulus(i * 50, 20, 19, 19);
            expectBox(i * 50, 20, 19, 19, 2);
        end
        endFrame(16, 1, lat);

        // Burst: six back-to-back hits while a ten-entry search is running
        for (int i = 0; i < 10; i++) applyStimulus(i * 60, 300, 19, 19);
        bx = '{0, 1, 2, 3, 4, 4};
        by = '{300, 301, 302, 303, 304, 304};
        step();
        det_valid = 1'b1;
        det_x = 10'd700; det_y = 9'd100; det_w = 10'd19; det_h = 9'd19;
        step();
        det_valid = 1'b0;
        for (int k = 0; k < 6; k++) begin
            step();
            det_valid = 1'b1;
            det_x = 10'(bx[k]);
            det_y = 9'(by[k]);
        end
        step();
        det_valid = 1'b0;
        waitIdle();
        expectBox(0, 300, 22, 22, 5);
        endFrame(1, 2, lat);

        // Backpressure then reset in the middle of the emit walk
        applyStimulus(300, 200, 19, 19);
        applyStimulus(300, 200, 19, 19);
        applyStimulus(400, 200, 19, 19);
        applyStimulus(400, 200, 19, 19);
        expectBox(300, 200, 19, 19, 2);
        expectBox(400, 200, 19, 19, 2);
        base      = done_count;
        out_ready = 1'b0;
        step();
        scan_busy = 1'b0;
        n = 0;
        while (!out_valid && n < 50) begin
            step();
            n++;
        end
        checkOutput("bp_valid_seen", int'(out_valid), 1);
        for (int k = 0; k < 5; k++) begin
            step();
            checkOutput("bp_hold_valid", int'(out_valid), 1);
            checkOutput("bp_hold_x", int'(out_x), 300);
            checkOutput("bp_hold_y", int'(out_y), 200);
            checkOutput("bp_hold_w", int'(out_w), 19);
            checkOutput("bp_hold_hits", int'(out_hits), 2);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        step();
        checkOutput("second_box_valid", int'(out_valid), 1);
        checkOutput("second_box_x", int'(out_x), 400);
        reset = 1'b1;
        step();
        checkOutput("mid_emit_reset_valid", int'(out_valid), 0);
        checkOutput("mid_emit_reset_busy", int'(busy), 0);
        checkOutput("mid_emit_reset_done", int'(frame_done), 0);
        reset = 1'b0;
        exp_q.delete();
        scan_busy = 1'b1;
        out_ready = 1'b1;
        repeat (10) step();
        checkOutput("no_frame_done_after_reset", done_count - base, 0);
        checkOutput("idle_after_reset", int'(busy), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, fail_count);
        $finish;
    end

endmodule
